// File: rtl/bht_pkg.sv
// Shared types and helpers for the 2-way set-associative branch target buffer.
// Entry fields are stored at their maximum widths; unused upper bits stay zero.
package bht_pkg;

    localparam int DEF_SET_LEN = 4;
    localparam int DEF_CNT_W   = 2;
    localparam int DEF_GHR_LEN = 4;
    localparam int TAG_MAX_W   = 30;
    localparam int CTR_MAX_W   = 8;

    typedef logic [TAG_MAX_W-1:0] tag_t;
    typedef logic [CTR_MAX_W-1:0] ctr_t;

    typedef struct packed {
        logic        valid;
        tag_t        tag;
        logic [31:0] target;
        ctr_t        ctr;
    } entry_t;

    function automatic int tag_width(input int set_len);
        return 32 - set_len - 2;
    endfunction

    function automatic ctr_t ctr_max(input int cnt_w);
        return ctr_t'((1 << cnt_w) - 1);
    endfunction

    // Allocation value: MSB set, rest clear (weakly taken; 1 when cnt_w == 1)
    function automatic ctr_t weak_init(input int cnt_w);
        return ctr_t'(1 << (cnt_w - 1));
    endfunction

    function automatic ctr_t sat_inc(input ctr_t c, input int cnt_w);
        return (c >= ctr_max(cnt_w)) ? c : c + ctr_t'(1);
    endfunction

    function automatic ctr_t sat_dec(input ctr_t c);
        return (c == '0) ? c : c - ctr_t'(1);
    endfunction

endpackage

// File: rtl/bht_assoc_if.sv
// Fetch/execute signal bundle for bht_assoc; master drives the pipeline side,
// slave is the predictor.
interface bht_assoc_if #(
    parameter int GHR_LEN = 4
);
    logic [31:0]        PCF;
    logic               PredF;
    logic               HitF;
    logic [31:0]        NPC_PredF;
    logic               UpdE;
    logic [31:0]        PCE;
    logic               BranchE;
    logic [31:0]        BrNPC;
    logic               PredE;
    logic [31:0]        NPC_PredE;
    logic               MispredE;
    logic [GHR_LEN-1:0] GhrF;
    logic [GHR_LEN-1:0] GhrE;

    modport master (
        output PCF, UpdE, PCE, BranchE, BrNPC, PredE, NPC_PredE, GhrE,
        input  PredF, HitF, NPC_PredF, MispredE, GhrF
    );

    modport slave (
        input  PCF, UpdE, PCE, BranchE, BrNPC, PredE, NPC_PredE, GhrE,
        output PredF, HitF, NPC_PredF, MispredE, GhrF
    );
endinterface

// File: rtl/bht_way_lookup.sv
// Per-way tag compare: hit when valid and tags match; pred is the hit-qualified
// counter MSB.
module bht_way_lookup
    import bht_pkg::*;
(
    input  logic valid,
    input  tag_t entry_tag,
    input  tag_t pc_tag,
    input  logic ctr_msb,
    output logic hit,
    output logic pred
);
    assign hit  = valid && (entry_tag == pc_tag);
    assign pred = hit && ctr_msb;
endmodule

// File: rtl/bht_assoc.sv
// 2-way set-associative BTB with saturating counters and per-set LRU.
// Optional gshare indexing is enabled by defining BHT_GSHARE_EN.
module bht_assoc
    import bht_pkg::*;
#(
    parameter int SET_LEN = DEF_SET_LEN,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int GHR_LEN = DEF_GHR_LEN
) (
    input logic        clk,
    input logic        rst,
    bht_assoc_if.slave bus
);
    localparam int   SETS     = 1 << SET_LEN;
    localparam int   TAG_W    = tag_width(SET_LEN);
    localparam ctr_t INIT_CTR = weak_init(CNT_W);

    entry_t            entry_reg [SETS][2];
    logic [SETS-1:0]   lru_reg;

    logic [SET_LEN-1:0] lidx;
    logic [SET_LEN-1:0] uidx;
    logic [TAG_W-1:0]   pcf_tag_raw;
    logic [TAG_W-1:0]   pce_tag_raw;
    tag_t               ltag;
    tag_t               utag;
    logic [1:0]         lhit;
    logic [1:0]         lpred;
    logic [1:0]         uhit;
    logic [1:0]         unused_upred;
    logic               unused_pc_bits;
    logic               uway;
    logic               victim;
    ctr_t               cur_ctr;

    assign pcf_tag_raw    = bus.PCF[31:SET_LEN+2];
    assign pce_tag_raw    = bus.PCE[31:SET_LEN+2];
    assign ltag           = tag_t'(pcf_tag_raw);
    assign utag           = tag_t'(pce_tag_raw);
    assign unused_pc_bits = ^{bus.PCF[1:0], bus.PCE[1:0]};

`ifdef BHT_GSHARE_EN
    logic [GHR_LEN-1:0] ghr_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ghr_reg <= '0;
        end else if (bus.UpdE) begin
            ghr_reg <= GHR_LEN'({ghr_reg, bus.BranchE});
        end
    end

    // Tag stays pure PC; only the set index is hashed with history
    assign lidx     = bus.PCF[SET_LEN+1:2] ^ SET_LEN'(ghr_reg);
    assign uidx     = bus.PCE[SET_LEN+1:2] ^ SET_LEN'(bus.GhrE);
    assign bus.GhrF = ghr_reg;
`else
    logic unused_ghre;

    assign lidx        = bus.PCF[SET_LEN+1:2];
    assign uidx        = bus.PCE[SET_LEN+1:2];
    assign bus.GhrF    = '0;
    assign unused_ghre = ^bus.GhrE;
`endif

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_way
            bht_way_lookup u_look (
                .valid     (entry_reg[lidx][gi].valid),
                .entry_tag (entry_reg[lidx][gi].tag),
                .pc_tag    (ltag),
                .ctr_msb   (entry_reg[lidx][gi].ctr[CNT_W-1]),
                .hit       (lhit[gi]),
                .pred      (lpred[gi])
            );

            bht_way_lookup u_upd (
                .valid     (entry_reg[uidx][gi].valid),
                .entry_tag (entry_reg[uidx][gi].tag),
                .pc_tag    (utag),
                .ctr_msb   (entry_reg[uidx][gi].ctr[CNT_W-1]),
                .hit       (uhit[gi]),
                .pred      (unused_upred[gi])
            );
        end
    endgenerate

    assign bus.HitF  = |lhit;
    assign bus.PredF = |lpred;

    always_comb begin
        bus.NPC_PredF = '0;
        if (lhit[0]) begin
            bus.NPC_PredF = entry_reg[lidx][0].target;
        end else if (lhit[1]) begin
            bus.NPC_PredF = entry_reg[lidx][1].target;
        end
    end

    assign bus.MispredE = bus.UpdE &&
                          ((bus.PredE != bus.BranchE) ||
                           (bus.BranchE && bus.PredE && (bus.NPC_PredE != bus.BrNPC)));

    // Victim prefers an invalid way (way0 first), otherwise the LRU way
    always_comb begin
        uway    = ~uhit[0];
        cur_ctr = entry_reg[uidx][uway].ctr;
        if (!entry_reg[uidx][0].valid) begin
            victim = 1'b0;
        end else if (!entry_reg[uidx][1].valid) begin
            victim = 1'b1;
        end else begin
            victim = lru_reg[uidx];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < 2; w++) begin
                    entry_reg[s][w] <= '0;
                end
            end
            lru_reg <= '0;
        end else if (bus.UpdE) begin
            if (|uhit) begin
                if (bus.BranchE) begin
                    entry_reg[uidx][uway].ctr    <= sat_inc(cur_ctr, CNT_W);
                    entry_reg[uidx][uway].target <= bus.BrNPC;
                end else begin
                    entry_reg[uidx][uway].ctr    <= sat_dec(cur_ctr);
                end
                lru_reg[uidx] <= ~uway;
            end else if (bus.BranchE) begin
                entry_reg[uidx][victim] <= entry_t'{valid:  1'b1,
                                                    tag:    utag,
                                                    target: bus.BrNPC,
                                                    ctr:    INIT_CTR};
                lru_reg[uidx] <= ~victim;
            end
        end
    end

endmodule

// File: tb/tb_bht_assoc.sv
// Randomised self-checking bench for bht_assoc against a recency-based
// reference model of the two-way buffer.
module tb_bht_assoc;
    localparam int SET_LEN = 4;
    localparam int CNT_W   = 2;
    localparam int GHR_LEN = 4;
    localparam int SETS    = 1 << SET_LEN;
    localparam int CMAX    = (1 << CNT_W) - 1;
    localparam int CINIT   = 1 << (CNT_W - 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   txn = 0;

    bht_assoc_if #(.GHR_LEN(GHR_LEN)) bus ();

    bht_assoc #(.SET_LEN(SET_LEN), .CNT_W(CNT_W), .GHR_LEN(GHR_LEN)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: each set is two slots plus the slot touched most recently
    bit          m_valid [SETS][2];
    int unsigned m_tag   [SETS][2];
    logic [31:0] m_tgt   [SETS][2];
    int          m_ctr   [SETS][2];
    int          m_last  [SETS];
    int unsigned m_ghr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < 2; w++) begin
                m_valid[s][w] = 0;
                m_tag[s][w]   = 0;
                m_tgt[s][w]   = 0;
                m_ctr[s][w]   = 0;
            end
            m_last[s] = 1;
        end
        m_ghr = 0;
    endtask

    function automatic int m_set(input logic [31:0] pc, input int unsigned g);
        int s;
        s = int'((pc >> 2) % SETS);
`ifdef BHT_GSHARE_EN
        s = s ^ int'(g % (1 << GHR_LEN));
`else
        if (g > 32'hffff_ffff) s = 0;
`endif
        return s;
    endfunction

    function automatic int m_find(input logic [31:0] pc, input int unsigned g);
        int s;
        s = m_set(pc, g);
        for (int w = 0; w < 2; w++)
            if (m_valid[s][w] && m_tag[s][w] == (pc >> (SET_LEN + 2))) return w;
        return -1;
    endfunction

    task automatic m_update(input logic [31:0] pc, input int unsigned g, input bit br,
                            input logic [31:0] tgt);
        int s;
        int w;
        s = m_set(pc, g);
        w = m_find(pc, g);
        if (w >= 0) begin
            if (br) begin
                if (m_ctr[s][w] < CMAX) m_ctr[s][w]++;
                m_tgt[s][w] = tgt;
            end else if (m_ctr[s][w] > 0) begin
                m_ctr[s][w]--;
            end
            m_last[s] = w;
        end else if (br) begin
            if (!m_valid[s][0])      w = 0;
            else if (!m_valid[s][1]) w = 1;
            else                     w = 1 - m_last[s];
            m_valid[s][w] = 1;
            m_tag[s][w]   = pc >> (SET_LEN + 2);
            m_tgt[s][w]   = tgt;
            m_ctr[s][w]   = CINIT;
            m_last[s]     = w;
        end
        m_ghr = ((m_ghr << 1) | int'(br)) % (1 << GHR_LEN);
    endtask

    // One transaction: drive, check the combinational outputs, clock, update model
    task automatic step(input logic [31:0] pcf, input bit upd, input logic [31:0] pce,
                        input bit br, input logic [31:0] tgt, input bit prede,
                        input logic [31:0] npce);
        int          w;
        int          s;
        bit          e_hit;
        bit          e_pred;
        logic [31:0] e_npc;
        bit          e_mis;
        int unsigned ghre;
`ifdef BHT_GSHARE_EN
        ghre = m_ghr;
`else
        ghre = $urandom % (1 << GHR_LEN);
`endif
        bus.PCF       = pcf;
        bus.UpdE      = upd;
        bus.PCE       = pce;
        bus.BranchE   = br;
        bus.BrNPC     = tgt;
        bus.PredE     = prede;
        bus.NPC_PredE = npce;
        bus.GhrE      = GHR_LEN'(ghre);
        #1;
        w      = m_find(pcf, m_ghr);
        s      = m_set(pcf, m_ghr);
        e_hit  = (w >= 0);
        e_pred = e_hit && (m_ctr[s][w] >= CINIT);
        e_npc  = e_hit ? m_tgt[s][w] : 32'h0;
        e_mis  = upd && ((prede != br) || (br && prede && npce != tgt));
        check("HitF", bus.HitF, e_hit);
        check("PredF", bus.PredF, e_pred);
        check("NPC_PredF", bus.NPC_PredF, e_npc);
        check("MispredE", bus.MispredE, e_mis);
`ifdef BHT_GSHARE_EN
        check("GhrF", bus.GhrF, m_ghr);
`else
        check("GhrF", bus.GhrF, 0);
`endif
        $display("txn %0d pcf=%h hit=%0d pred=%0d npc=%h upd=%0d pce=%h br=%0d mis=%0d",
                 txn, pcf, bus.HitF, bus.PredF, bus.NPC_PredF, upd, pce, br, bus.MispredE);
        txn++;
        @(posedge clk);
        if (upd) m_update(pce, ghre, br, tgt);
        #1;
    endtask

    function automatic logic [31:0] rand_pc();
        return 32'h1000 | (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 15)) << 2);
    endfunction

    initial begin
        logic [31:0] pcf;
        logic [31:0] pce;
        logic [31:0] npce;
        bit          prede;
        int          w;
        int          s;

        m_reset();
        bus.PCF = 32'h100; bus.UpdE = 0; bus.PCE = 0; bus.BranchE = 0; bus.BrNPC = 0;
        bus.PredE = 0; bus.NPC_PredE = 0; bus.GhrE = '0;
        #2;
        check("rst_HitF", bus.HitF, 0);
        check("rst_PredF", bus.PredF, 0);
        check("rst_NPC", bus.NPC_PredF, 0);
        #10 rst = 1'b0;

        // Allocation, saturation and decrement of one branch
        step(32'h100, 1, 32'h100, 1, 32'h200, 0, 0);
        step(32'h100, 0, 0, 0, 0, 0, 0);
`ifndef BHT_GSHARE_EN
        check("alloc_hit", bus.HitF, 1);
        check("alloc_pred", bus.PredF, 1);
        check("alloc_npc", bus.NPC_PredF, 32'h200);
`endif
        repeat (3) step(32'h100, 1, 32'h100, 1, 32'h200, 1, 32'h200);
        repeat (2) step(32'h100, 1, 32'h100, 0, 0, 1, 32'h200);
`ifndef BHT_GSHARE_EN
        check("dec_hit", bus.HitF, 1);
        check("dec_pred", bus.PredF, 0);
        check("dec_npc", bus.NPC_PredF, 32'h200);
`endif
        step(32'h100, 0, 0, 0, 0, 0, 0);

        // Three taken branches in set 0: the LRU entry is evicted
        step(32'h140, 1, 32'h140, 1, 32'h240, 0, 0);
        step(32'h180, 1, 32'h180, 1, 32'h280, 0, 0);
        step(32'h100, 0, 0, 0, 0, 0, 0);
`ifndef BHT_GSHARE_EN
        check("evict_100", bus.HitF, 0);
`endif
        step(32'h140, 0, 0, 0, 0, 0, 0);
        step(32'h180, 0, 0, 0, 0, 0, 0);

        // Not-taken miss allocates nothing
        step(32'h300, 1, 32'h300, 0, 32'h304, 0, 0);
        step(32'h300, 0, 0, 0, 0, 0, 0);

        // Target mismatch on a correctly predicted direction
        step(32'h500, 1, 32'h500, 1, 32'h204, 1, 32'h200);
        step(32'h500, 1, 32'h500, 1, 32'h200, 1, 32'h200);

        // Asynchronous reset between edges clears lookups immediately
        bus.PCF  = 32'h500;
        bus.UpdE = 1;
        #1 rst = 1'b1;
        #1;
        check("arst_HitF", bus.HitF, 0);
        check("arst_PredF", bus.PredF, 0);
        check("arst_NPC", bus.NPC_PredF, 0);
        m_reset();
        #1 rst = 1'b0;

`ifdef BHT_GSHARE_EN
        step(32'h600, 1, 32'h600, 1, 32'h700, 0, 0);
        step(32'h600, 1, 32'h604, 1, 32'h700, 0, 0);
        step(32'h600, 1, 32'h608, 0, 32'h700, 0, 0);
        check("ghr_TTN", bus.GhrF, 32'h6);
`endif

        // Random traffic over a small PC pool to force conflicts and evictions
        for (int i = 0; i < 300; i++) begin
            pcf = rand_pc();
            pce = rand_pc();
            s   = m_set(pce, m_ghr);
            w   = m_find(pce, m_ghr);
            prede = (w >= 0) && (m_ctr[s][w] >= CINIT);
            npce  = (w >= 0) ? m_tgt[s][w] : 32'h0;
            if ($urandom_range(0, 4) == 0) begin
                prede = 1'($urandom);
                npce  = 32'($urandom_range(0, 3)) << 2 | 32'h2000;
            end
            step(pcf, ($urandom_range(0, 9) < 7), pce, 1'($urandom),
                 32'h2000 | (32'($urandom_range(0, 3)) << 2), prede, npce);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/bht_assoc.md
Name: bht_assoc

Overview:
- Next-generation branch predictor: 2-way set-associative branch target buffer with parametrised set count and saturating-counter width.
- Per-set LRU replacement and a combinational mispredict flag for the execute stage.
- Fetch stage looks up PCF combinationally and gets a taken prediction plus predicted next PC.
- Execute stage writes back the resolved outcome; optional gshare indexing driven by a global history register.

Parameters:
SET_LEN, 4, log2 of number of sets (SETS = 1<<SET_LEN)
CNT_W, 2, saturating counter width in bits (>=1)
GHR_LEN, 4, global history length, used only with BHT_GSHARE_EN (<= SET_LEN)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous active-high reset
PCF  in  32  fetch-stage PC
PredF  out  1  predict taken
HitF  out  1  PCF hits a valid entry
NPC_PredF  out  32  predicted target; 0 on miss
UpdE  in  1  execute stage holds a resolved conditional branch
PCE  in  32  execute-stage PC
BranchE  in  1  branch actually taken
BrNPC  in  32  actual branch target
PredE  in  1  PredF carried down the pipeline
NPC_PredE  in  32  NPC_PredF carried down the pipeline
MispredE  out  1  execute-stage misprediction flag
GhrF  out  GHR_LEN  history snapshot (BHT_GSHARE_EN only)
GhrE  in  GHR_LEN  snapshot carried to execute (BHT_GSHARE_EN only)

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is asynchronous and active-high.
- Index and tag:
  - idx = PC[SET_LEN+1:2]; tag = PC[31:SET_LEN+2] (full tag, no aliasing).
- Entry contents, per set and way: valid, tag, target[31:0], ctr[CNT_W-1:0]. Each set also holds one LRU bit naming the next victim way.
- Lookup (combinational, zero latency):
  - HitF = a valid way in set idx(PCF) with matching tag.
  - PredF = HitF && ctr[CNT_W-1] of the hit way.
  - NPC_PredF = target of the hit way, else 0.
- MispredE (combinational) = UpdE && ((PredE != BranchE) || (BranchE && PredE && NPC_PredE != BrNPC)).
- Update (rising edge, only when UpdE=1):
  - Hit and taken: ctr saturating +1 (max 2^CNT_W-1); target<=BrNPC; LRU<=other way.
  - Hit and not taken: ctr saturating -1 (min 0); target and valid unchanged; LRU<=other way.
  - Miss and taken: allocate the victim way. Victim = first invalid way (way0 preferred), else the LRU way. Set valid=1, tag, target=BrNPC, ctr=2^(CNT_W-1) (weakly taken); LRU<=other way.
  - Miss and not taken: no state change.
- UpdE=0: no state change.
- Allocation happens only on a miss, so both ways never hit the same tag. The implementation may use a priority select (way0 wins).
- Simultaneous lookup and update to the same set: the lookup sees pre-edge contents; no bypass.
- Reset (including mid-operation): all valid=0, ctr=0, target=0, tag=0, LRU=0, GHR=0. Outputs then read PredF=0, HitF=0, NPC_PredF=0, and MispredE follows its inputs.
- CNT_W=1: the counter degenerates to last-outcome; allocate value is 1.

Optional Feature:
- Macro BHT_GSHARE_EN.
- Defined:
  - GHR[GHR_LEN-1:0] register. On an UpdE edge it shifts left with BranchE inserted at bit 0.
  - Lookup index = idx(PCF) XOR {0, GHR}; GhrF = GHR.
  - Update index = idx(PCE) XOR {0, GhrE}.
  - Tag stays pure PC.
- Undefined: no GHR; GhrF driven 0; GhrE ignored; plain PC indexing.

Decomposition:
- Package bht_pkg holds:
  - entry struct typedef (valid, tag, target, ctr);
  - sat_inc/sat_dec functions parametrised on CNT_W;
  - localparams for weakly-taken init and tag width.
- Sub-module bht_way_lookup, instanced per way: tag compare, hit, ctr MSB.
- Top level holds the arrays, LRU and victim select.

Test Plan:
- Reset then PCF=0x100 -> HitF=0, PredF=0, NPC_PredF=0. Apply UpdE=1, PCE=0x100, BranchE=1, BrNPC=0x200 -> next cycle HitF=1, PredF=1, NPC_PredF=0x200, ctr=2.
- Saturation: same branch taken 3 more times -> ctr stays 3. Then not-taken twice -> ctr=1, PredF=0, HitF=1, target still 0x200.
- Conflict (SET_LEN=4): taken branches at 0x100, 0x140, 0x180 (same set 0) -> 0x180 evicts 0x100 (LRU); 0x140 and 0x180 hit, 0x100 misses.
- Miss not-taken: UpdE, PCE=0x300, BranchE=0 -> no allocation; HitF=0 at PCF=0x300.
- Mispredict: UpdE=1, PredE=1, NPC_PredE=0x200, BranchE=1, BrNPC=0x204 -> MispredE=1. Same with BrNPC=0x200 -> MispredE=0.
- Async reset asserted mid-update between edges -> all entries invalid immediately, HitF=0 without a clock edge. With BHT_GSHARE_EN: after outcomes T,T,N, GhrF=4'b0110.
